// File: rtl/sample2uart_mc.sv
// rtl/sample2uart_mc.sv - multi-channel sample set to UART byte serializer; define SAMPLE2UART_SYNC_HEADER_EN to prefix each set with sync bytes 0xA5,0x5A
module sample2uart_mc #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int NUM_CHANNELS = 2,
  parameter int LSB_FIRST    = 1,
  parameter int GUARD_CYCLES = 1
) (
  input  logic                                 in_clk,
  input  logic                                 in_rst,
  input  logic                                 in_sample_valid,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] in_samples,
  input  logic                                 tx_busy,
  output logic [7:0]                           out_uart_frame,
  output logic                                 out_ready,
  output logic                                 out_busy,
  output logic [7:0]                           out_drop_count
);

  localparam int BYTES_PER_SAMPLE = SAMPLE_WIDTH / 8;
  localparam int PAYLOAD_BYTES    = NUM_CHANNELS * BYTES_PER_SAMPLE;
`ifdef SAMPLE2UART_SYNC_HEADER_EN
  localparam int HDR_BYTES        = 2;
`else
  localparam int HDR_BYTES        = 0;
`endif
  localparam int BYTES            = PAYLOAD_BYTES + HDR_BYTES;
  localparam int IDX_W            = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BYTES - 1);
  localparam logic [3:0]       GUARD_LOAD = 4'(GUARD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT
  } state_t;

  state_t                              r_state;
  state_t                              w_next;
  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] r_cap;
  logic [IDX_W-1:0]                    r_idx;
  logic [3:0]                          r_guard;
  logic [7:0]                          r_frame;
  logic                                r_ready;
  logic [7:0]                          r_drop;
  logic                                w_accept;
  logic                                w_load;
  logic                                w_advance;
  logic [7:0]                          w_bytes [BYTES];

  // Send-order byte table: optional header, then channel 0 upward, bytes within
  // a sample in ascending or descending significance depending on LSB_FIRST.
`ifdef SAMPLE2UART_SYNC_HEADER_EN
  assign w_bytes[0] = 8'hA5;
  assign w_bytes[1] = 8'h5A;
`endif
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    for (genvar j = 0; j < BYTES_PER_SAMPLE; j++) begin : g_byte
      localparam int K = (LSB_FIRST != 0) ? j : (BYTES_PER_SAMPLE - 1 - j);
      assign w_bytes[HDR_BYTES + c*BYTES_PER_SAMPLE + j] = r_cap[c*SAMPLE_WIDTH + 8*K +: 8];
    end
  end

  // State register.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control strobes; acceptance only from IDLE with TX idle.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_load    = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_sample_valid && !tx_busy) begin
          w_accept = 1'b1;
          w_next   = S_LOAD;
        end
      end
      S_LOAD: begin
        w_load = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (r_guard == 4'd0 && !tx_busy) begin
          if (r_idx != LAST_IDX) begin
            w_advance = 1'b1;
            w_next    = S_LOAD;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the whole set at acceptance so later input changes cannot leak in.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_cap <= '0;
    end else if (w_accept) begin
      r_cap <= in_samples;
    end
  end

  // Byte index: cleared at acceptance, stepped after each completed handshake.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_idx <= '0;
    end else if (w_accept) begin
      r_idx <= '0;
    end else if (w_advance) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  // Guard counter masks the TX block's late busy assertion after each strobe.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_guard <= 4'd0;
    end else if (w_load) begin
      r_guard <= GUARD_LOAD;
    end else if (r_state == S_WAIT && r_guard != 4'd0) begin
      r_guard <= r_guard - 4'd1;
    end
  end

  // Frame register holds the last byte; ready is a one-cycle strobe per byte.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_frame <= 8'h00;
      r_ready <= 1'b0;
    end else begin
      r_ready <= w_load;
      if (w_load) begin
        r_frame <= w_bytes[r_idx];
      end
    end
  end

  // Saturating count of sets offered while a set is still in flight.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_drop <= 8'h00;
    end else if (in_sample_valid && r_state != S_IDLE && r_drop != 8'hFF) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  assign out_uart_frame = r_frame;
  assign out_ready      = r_ready;
  assign out_busy       = (r_state != S_IDLE);
  assign out_drop_count = r_drop;

endmodule
